// File: rtl/delay_ctrl.sv
// Front-panel control stage: synchronises and debounces the push-buttons and frequency
// switch, and maintains the saturating 7-bit delay setting with hold-to-auto-repeat.
module delay_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000,
    parameter int DELAY_INIT      = 10,
    parameter int DELAY_MAX       = 127
) (
    input  logic       m_clk,
    input  logic       m_rst_n,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_clr,
    input  logic       sw_freq,
    output logic [6:0] delay,
    output logic       set_freq,
    output logic       changed,
    output logic       at_min,
    output logic       at_max
);

    localparam int NIN = 4;
    localparam int IDX_UP  = 0;
    localparam int IDX_DN  = 1;
    localparam int IDX_CLR = 2;
    localparam int IDX_SW  = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic [NIN-1:0] raw;
    logic [NIN-1:0] deb_level;
    logic [NIN-1:0] deb_prev_reg;

    assign raw = {sw_freq, btn_clr, btn_dn, btn_up};

    // Per input: 2-FF synchroniser followed by a consecutive-disagreement debouncer.
    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_in
            logic        s1_reg;
            logic        s2_reg;
            logic        level_reg;
            logic [31:0] cnt_reg;

            always_ff @(posedge m_clk or negedge m_rst_n) begin
                if (!m_rst_n) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    s1_reg <= raw[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg != level_reg) begin
                        if (cnt_reg == 32'(DEBOUNCE_CYCLES - 1)) begin
                            level_reg <= s2_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign deb_level[gi] = level_reg;
        end
    endgenerate

    logic up_lvl, dn_lvl, up_rise, dn_rise, clr_rise, both;

    assign up_lvl   = deb_level[IDX_UP];
    assign dn_lvl   = deb_level[IDX_DN];
    assign up_rise  = deb_level[IDX_UP]  & ~deb_prev_reg[IDX_UP];
    assign dn_rise  = deb_level[IDX_DN]  & ~deb_prev_reg[IDX_DN];
    assign clr_rise = deb_level[IDX_CLR] & ~deb_prev_reg[IDX_CLR];
    assign both     = up_lvl & dn_lvl;

    state_t      state_reg, state_next;
    logic [31:0] hold_reg, hold_next;
    logic        dir_up_reg, dir_up_next;
    logic        step_up, step_dn;
    logic        active;

    assign active = dir_up_reg ? up_lvl : dn_lvl;

    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        dir_up_next = dir_up_reg;
        step_up     = 1'b0;
        step_dn     = 1'b0;
        case (state_reg)
            IDLE: begin
                hold_next = '0;
                if (!both) begin
                    if (up_rise) begin
                        step_up     = 1'b1;
                        dir_up_next = 1'b1;
                        state_next  = HOLD;
                    end else if (dn_rise) begin
                        step_dn     = 1'b1;
                        dir_up_next = 1'b0;
                        state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (both || !active) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else if (hold_reg == 32'(REPEAT_DELAY - 1)) begin
                    step_up    = dir_up_reg;
                    step_dn    = !dir_up_reg;
                    hold_next  = '0;
                    state_next = REPEAT;
                end else begin
                    hold_next = hold_reg + 32'd1;
                end
            end
            REPEAT: begin
                if (both || !active) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else if (hold_reg == 32'(REPEAT_RATE - 1)) begin
                    step_up   = dir_up_reg;
                    step_dn   = !dir_up_reg;
                    hold_next = '0;
                end else begin
                    hold_next = hold_reg + 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = '0;
            end
        endcase
    end

    logic [6:0] delay_reg, delay_next;
    logic       set_freq_reg;
    logic       changed_reg, changed_next;

    // Clear outranks stepping; saturated steps leave the value untouched.
    always_comb begin
        delay_next = delay_reg;
        if (clr_rise) begin
            delay_next = 7'(DELAY_INIT);
        end else if (step_up && (delay_reg != 7'(DELAY_MAX))) begin
            delay_next = delay_reg + 7'd1;
        end else if (step_dn && (delay_reg != 7'd0)) begin
            delay_next = delay_reg - 7'd1;
        end
        changed_next = (delay_next != delay_reg) || (deb_level[IDX_SW] != set_freq_reg);
    end

    always_ff @(posedge m_clk or negedge m_rst_n) begin
        if (!m_rst_n) begin
            state_reg    <= IDLE;
            hold_reg     <= '0;
            dir_up_reg   <= 1'b0;
            deb_prev_reg <= '0;
            delay_reg    <= 7'(DELAY_INIT);
            set_freq_reg <= 1'b0;
            changed_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            dir_up_reg   <= dir_up_next;
            deb_prev_reg <= deb_level;
            delay_reg    <= delay_next;
            set_freq_reg <= deb_level[IDX_SW];
            changed_reg  <= changed_next;
        end
    end

    assign delay    = delay_reg;
    assign set_freq = set_freq_reg;
    assign changed  = changed_reg;
    assign at_min   = (delay_reg == 7'd0);
    assign at_max   = (delay_reg == 7'(DELAY_MAX));

endmodule

// File: tb/tb_delay_ctrl.sv
// Scoreboard bench for delay_ctrl: stimulus pushes expected (cycle, delay, set_freq)
// for every changed strobe; a negedge monitor pops and compares.
module tb_delay_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_up, btn_dn, btn_clr, sw_freq;
    logic [6:0] delay;
    logic       set_freq, changed, at_min, at_max;

    typedef struct {
        int         cyc;
        logic [6:0] d;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   exp_delay = 10;
    logic exp_freq = 1'b0;

    delay_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5),
        .DELAY_INIT(10),
        .DELAY_MAX(127)
    ) dut (
        .m_clk(clk),
        .m_rst_n(rst_n),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .btn_clr(btn_clr),
        .sw_freq(sw_freq),
        .delay(delay),
        .set_freq(set_freq),
        .changed(changed),
        .at_min(at_min),
        .at_max(at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic push(input int t, input int d, input logic f);
        exp_t e;
        e.cyc = t;
        e.d   = 7'(d);
        e.f   = f;
        exp_q.push_back(e);
    endtask

    // Monitor: every changed strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && changed) begin
            if (exp_q.size() == 0) begin
                check("unexpected_changed", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_delay", int'(delay), int'(e.d));
                check("strobe_freq", int'(set_freq), int'(e.f));
            end
        end
    end

    // Hold one button for len cycles; steps land at +7, +27, then every 5 cycles
    // while the debounced level is still high (up to len+6).
    task automatic hold_btn(input bit up, input int len);
        int t0;
        int t;
        int nd;
        t0 = cyc;
        t  = 7;
        while (t <= len + 6) begin
            nd = exp_delay + (up ? 1 : -1);
            if (nd >= 0 && nd <= 127) begin
                exp_delay = nd;
                push(t0 + t, exp_delay, exp_freq);
            end
            t = (t == 7) ? 27 : t + 5;
        end
        if (up) btn_up = 1'b1;
        else    btn_dn = 1'b1;
        repeat (len) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0; sw_freq = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_delay", int'(delay), 10);
        check("reset_set_freq", int'(set_freq), 0);
        check("reset_changed", int'(changed), 0);
        check("reset_at_min", int'(at_min), 0);
        check("reset_at_max", int'(at_max), 0);

        // 3-cycle glitch must be filtered
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        repeat (15) @(negedge clk);
        check("glitch_delay", int'(delay), 10);

        // hold up 40 cycles: 11@7, 12@27, 13@32, 14@37, 15@42
        hold_btn(1'b1, 40);
        check("hold_up_delay", int'(delay), 15);

        // hold down long enough to reach and sit at 0
        hold_btn(1'b0, 120);
        check("sat_min_delay", int'(delay), 0);
        check("sat_min_at_min", int'(at_min), 1);

        // hold up long enough to reach and sit at 127
        hold_btn(1'b1, 660);
        check("sat_max_delay", int'(delay), 127);
        check("sat_max_at_max", int'(at_max), 1);

        // clear reloads the initial value, 7 cycles after the press
        t0 = cyc;
        exp_delay = 10;
        push(t0 + 7, 10, exp_freq);
        btn_clr = 1'b1;
        repeat (10) @(negedge clk);
        btn_clr = 1'b0;
        repeat (12) @(negedge clk);
        check("clr_delay", int'(delay), 10);
        check("clr_at_max", int'(at_max), 0);

        // both buttons together: no stepping
        btn_up = 1'b1;
        btn_dn = 1'b1;
        repeat (30) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (12) @(negedge clk);
        check("both_delay", int'(delay), 10);

        // frequency switch 0->1 then back, each 2+4+1 cycles later
        t0 = cyc;
        exp_freq = 1'b1;
        push(t0 + 7, exp_delay, 1'b1);
        sw_freq = 1'b1;
        repeat (12) @(negedge clk);
        check("freq_high", int'(set_freq), 1);
        t0 = cyc;
        exp_freq = 1'b0;
        push(t0 + 7, exp_delay, 1'b0);
        sw_freq = 1'b0;
        repeat (12) @(negedge clk);
        check("freq_low", int'(set_freq), 0);

        // reset in the middle of auto-repeat
        t0 = cyc;
        push(t0 + 7, 11, 1'b0);
        push(t0 + 27, 12, 1'b0);
        push(t0 + 32, 13, 1'b0);
        btn_up = 1'b1;
        repeat (35) @(negedge clk);
        check("pre_reset_delay", int'(delay), 13);
        rst_n = 1'b0;
        btn_up = 1'b0;
        #1;
        check("async_reset_delay", int'(delay), 10);
        check("async_reset_changed", int'(changed), 0);
        exp_delay = 10;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_delay", int'(delay), 10);

        // fresh press after reset works normally
        hold_btn(1'b1, 10);
        check("post_reset_step", int'(delay), 11);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
